id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Priority per cycle: stall (hold) > bubble (clear) > load (capture decode fields).
// bubbleCount is a saturating 16-bit tally of inserted bubbles.
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            validD,
    input  logic            stallE,
    input  logic            flushE,
    input  logic [2:0]      ALUControlD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            ALUSrcD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      funct3D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic [2:0]      ALUControlE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      funct3E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            validE,
    output logic            lwStallD,
    output logic [15:0]     bubbleCount
);

    localparam logic [1:0]  ResLoad = 2'b01;
    localparam logic [15:0] CntMax  = 16'hFFFF;

    logic            bubble;
    logic            load;

    logic [2:0]      alucontrol_d;
    logic            regwrite_d;
    logic            memwrite_d;
    logic            alusrc_d;
    logic            jump_d;
    logic            branch_d;
    logic [1:0]      resultsrc_d;
    logic [2:0]      funct3_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] immext_d;
    logic [XLEN-1:0] pcplus4_d;
    logic [4:0]      rs1_d;
    logic [4:0]      rs2_d;
    logic [4:0]      rd_d;
    logic            valid_d;
    logic [15:0]     bubblecount_d;

    // Load-use hazard: a valid load in E writing a nonzero register read by a valid D instruction.
    // A bubble leaves validE=0, so the request cannot re-fire off its own bubble.
    always_comb begin
        lwStallD = 1'b0;
        if (validE && (ResultSrcE == ResLoad) && (RdE != 5'd0) && validD &&
            ((RdE == Rs1D) || (RdE == Rs2D))) begin
            lwStallD = 1'b1;
        end
    end

    // Action decode; a flush coinciding with a load-use stall is a single bubble.
    always_comb begin
        bubble = !stallE && (flushE || lwStallD);
        load   = !stallE && !flushE && !lwStallD;
    end

    // Next-state for every E field: hold by default, clear on bubble, capture on load.
    always_comb begin
        alucontrol_d = ALUControlE;
        regwrite_d   = RegWriteE;
        memwrite_d   = MemWriteE;
        alusrc_d     = ALUSrcE;
        jump_d       = JumpE;
        branch_d     = BranchE;
        resultsrc_d  = ResultSrcE;
        funct3_d     = funct3E;
        rd1_d        = RD1E;
        rd2_d        = RD2E;
        pc_d         = PCE;
        immext_d     = ImmExtE;
        pcplus4_d    = PCPlus4E;
        rs1_d        = Rs1E;
        rs2_d        = Rs2E;
        rd_d         = RdE;
        valid_d      = validE;
        if (bubble) begin
            alucontrol_d = '0;
            regwrite_d   = 1'b0;
            memwrite_d   = 1'b0;
            alusrc_d     = 1'b0;
            jump_d       = 1'b0;
            branch_d     = 1'b0;
            resultsrc_d  = '0;
            funct3_d     = '0;
            rd1_d        = '0;
            rd2_d        = '0;
            pc_d         = '0;
            immext_d     = '0;
            pcplus4_d    = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            valid_d      = 1'b0;
        end else if (load) begin
            alucontrol_d = ALUControlD;
            // An empty decode slot must not cause architectural side effects downstream.
            regwrite_d   = RegWriteD & validD;
            memwrite_d   = MemWriteD & validD;
            jump_d       = JumpD & validD;
            branch_d     = BranchD & validD;
            alusrc_d     = ALUSrcD;
            resultsrc_d  = ResultSrcD;
            funct3_d     = funct3D;
            rd1_d        = RD1D;
            rd2_d        = RD2D;
            pc_d         = PCD;
            immext_d     = ImmExtD;
            pcplus4_d    = PCPlus4D;
            rs1_d        = Rs1D;
            rs2_d        = Rs2D;
            rd_d         = RdD;
            valid_d      = validD;
        end
    end

    // Saturating bubble counter next-state.
    always_comb begin
        bubblecount_d = bubbleCount;
        if (bubble && (bubbleCount != CntMax)) begin
            bubblecount_d = bubbleCount + 16'd1;
        end
    end

    // E-stage state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUControlE <= '0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ResultSrcE  <= '0;
            funct3E     <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            PCE         <= '0;
            ImmExtE     <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            validE      <= 1'b0;
            bubbleCount <= '0;
        end else begin
            ALUControlE <= alucontrol_d;
            RegWriteE   <= regwrite_d;
            MemWriteE   <= memwrite_d;
            ALUSrcE     <= alusrc_d;
            JumpE       <= jump_d;
            BranchE     <= branch_d;
            ResultSrcE  <= resultsrc_d;
            funct3E     <= funct3_d;
            RD1E        <= rd1_d;
            RD2E        <= rd2_d;
            PCE         <= pc_d;
            ImmExtE     <= immext_d;
            PCPlus4E    <= pcplus4_d;
            Rs1E        <= rs1_d;
            Rs2E        <= rs2_d;
            RdE         <= rd_d;
            validE      <= valid_d;
            bubbleCount <= bubblecount_d;
        end
    end

endmodule
